udp_tx_arbiter: RTL and testbench
=================================

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, mid-packet stall limit in clocks (used only with the macro in REQ-021).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port i_src_tdata, input, N_SRC*8, payload bytes; source k occupies bits [8k+7:8k].
REQ-006 SHALL have ports i_src_tvalid and i_src_tlast, input, N_SRC each, per-source valid and last.
REQ-007 SHALL have port o_src_tready, output, N_SRC, per-source ready.
REQ-008 SHALL have ports o_tx_udp_payload_axis_tdata/tvalid/tlast, output, 8/1/1, and i_tx_udp_payload_axis_tready, input, 1: the shared UDP payload TX stream.
REQ-009 SHALL have port o_grant, output, N_SRC, one-hot owner of the TX stream; all-zero when idle.
REQ-010 SHALL have port o_busy, output, 1, high while any packet owns the stream.

Function
REQ-011 SHALL implement FSM S_IDLE, S_FWD, S_ABORT, S_DRAIN; reset state S_IDLE.
REQ-012 S_IDLE: any i_src_tvalid high -> register one-hot grant to the round-robin winner, go S_FWD next cycle (1-cycle arbitration latency); no TX output and all o_src_tready low in S_IDLE.
REQ-013 Round-robin: search starts at index (last_grant+1) mod N_SRC, wraps; last_grant resets to N_SRC-1, so source 0 wins first after reset.
REQ-014 S_FWD: TX tdata/tvalid/tlast combinationally equal granted source's signals; o_src_tready[g] = i_tx_udp_payload_axis_tready; other readys low; zero added latency.
REQ-015 Grant SHALL be held for the whole packet; new requests, even from higher-priority sources, never preempt.
REQ-016 A transfer with tvalid, tready and tlast high in S_FWD -> S_IDLE; last_grant <= g; o_grant cleared next cycle; one idle bubble between packets.
REQ-017 Single-byte packet (first beat has tlast) SHALL be forwarded normally and release the grant.
REQ-018 A source deasserting tvalid mid-packet SHALL NOT lose its grant (without the REQ-021 feature).
REQ-019 o_busy SHALL be high in S_FWD, S_ABORT, S_DRAIN.

Reset
REQ-020 While i_rst_n is low at a clock edge: state S_IDLE, o_grant 0, last_grant N_SRC-1, stall counter 0, o_src_tready 0, TX tvalid/tlast 0, tdata 0, o_busy 0; a packet in progress SHALL be dropped silently, no tlast emitted.

Configuration
REQ-021 With macro UDP_TX_ARB_TIMEOUT_EN defined: stall counter increments each S_FWD cycle where granted tvalid is low, clears on any accepted beat; on reaching TIMEOUT_CYCLES -> S_ABORT.
REQ-022 S_ABORT: TX tdata 8'h00, tvalid 1, tlast 1; on tready -> S_DRAIN (terminates the downstream packet).
REQ-023 S_DRAIN: o_src_tready[g] high, beats discarded (TX tvalid 0); on accepted beat with tlast -> S_IDLE, last_grant <= g.
REQ-024 Without the macro: no stall counter, S_ABORT and S_DRAIN unreachable, TIMEOUT_CYCLES unused.

Structure
REQ-025 State encodings and the abort byte constant SHALL live in shared package udp_tx_arb_pkg.
REQ-026 Round-robin winner selection SHALL be sub-module rr_pick (inputs request vector, last index; output one-hot winner and index), combinational.

Verification
REQ-027 Reset, then sources 0 and 2 both request at once -> source 0 granted, its full packet forwarded, then source 2 after one bubble cycle.
REQ-028 All 4 sources request continuously, 3-byte packets -> grant order 0,1,2,3,0; no byte interleaving between packets.
REQ-029 Source 1 sends 5 bytes 0x11..0x15 while i_tx_udp_payload_axis_tready toggles 1,0,1,0 -> TX shows 0x11..0x15 in order, tlast only on 0x15, no duplicated or lost byte.
REQ-030 Source 3 mid-packet, source 0 asserts tvalid -> source 3 keeps grant until its tlast; source 0 granted next.
REQ-031 With UDP_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: source 2 sends 2 bytes then stalls 16 cycles -> TX emits 0x00 with tlast; its remaining bytes through tlast are consumed and not forwarded; o_busy falls after that tlast.
REQ-032 i_rst_n low for one cycle mid-packet -> next cycle all outputs zero, state S_IDLE; subsequent request from source 1 forwarded correctly.

Source files
------------

// File: rtl/udp_tx_arb_pkg.sv
// Shared definitions for the UDP TX payload arbiter: FSM state encoding,
// the byte used to terminate an aborted downstream packet, and a small
// helper for the round-robin search.
package udp_tx_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_ABORT = 2'd2,
        S_DRAIN = 2'd3
    } arb_state_e;

    // Byte emitted with tlast to close a downstream packet whose source stalled.
    localparam logic [7:0] ABORT_BYTE = 8'h00;

    // Index reached by stepping 'step' places past 'last', wrapping at n.
    function automatic int rr_next(input int last, input int step, input int n);
        return (last + step) % n;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// place after the last winner, wrapping around, and returns the first hit
// both as a one-hot vector and as an index.
module rr_pick
    import udp_tx_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  win_oh_o,
    output logic [IW-1:0] win_idx_o,
    output logic          win_vld_o
);

    // First requester after last_i in circular order wins.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        win_oh_o  = '0;
        win_idx_o = '0;
        win_vld_o = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = rr_next(int'(last_i), i, N);
            cand_idx = IW'(cand);
            if (!win_vld_o && req_i[cand_idx]) begin
                win_vld_o           = 1'b1;
                win_idx_o           = cand_idx;
                win_oh_o[cand_idx]  = 1'b1;
            end else begin
                win_vld_o = win_vld_o;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// UDP TX payload arbiter: N_SRC byte streams share one UDP payload stream.
// A source is granted in round-robin order and owns the stream for a whole
// packet (until its tlast is accepted); data passes through with no latency.
// Optional feature, macro UDP_TX_ARB_TIMEOUT_EN: a granted source stalling
// mid-packet for TIMEOUT_CYCLES clocks gets its downstream packet closed with
// an abort byte, and the rest of its packet is then drained and discarded.
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter int N_SRC          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_SRC*8-1:0]   i_src_tdata,
    input  logic [N_SRC-1:0]     i_src_tvalid,
    input  logic [N_SRC-1:0]     i_src_tlast,
    output logic [N_SRC-1:0]     o_src_tready,
    output logic [7:0]           o_tx_udp_payload_axis_tdata,
    output logic                 o_tx_udp_payload_axis_tvalid,
    output logic                 o_tx_udp_payload_axis_tlast,
    input  logic                 i_tx_udp_payload_axis_tready,
    output logic [N_SRC-1:0]     o_grant,
    output logic                 o_busy
);

    localparam int IW = $clog2(N_SRC);

    // Elaboration-time sanity checks on the configuration.
    if (N_SRC < 2 || N_SRC > 8) begin : g_bad_n_src
        $error("udp_tx_arbiter: N_SRC must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("udp_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e     state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [IW-1:0]  last_q, last_d;

`ifdef UDP_TX_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0]  stall_q, stall_d;
`endif

    logic [N_SRC-1:0] pick_oh_s;
    logic [IW-1:0]    pick_idx_s;
    logic             pick_vld_s;
    logic [7:0]       sel_data_s;
    logic             sel_valid_s;
    logic             sel_last_s;

    rr_pick #(
        .N  (N_SRC),
        .IW (IW)
    ) u_rr_pick (
        .req_i     (i_src_tvalid),
        .last_i    (last_q),
        .win_oh_o  (pick_oh_s),
        .win_idx_o (pick_idx_s),
        .win_vld_o (pick_vld_s)
    );

    // Signals of the currently granted source.
    assign sel_data_s  = i_src_tdata[{gidx_q, 3'b000} +: 8];
    assign sel_valid_s = i_src_tvalid[gidx_q];
    assign sel_last_s  = i_src_tlast[gidx_q];

    assign o_grant = grant_q;

    // State register with grant ownership and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(N_SRC - 1);
`ifdef UDP_TX_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
`ifdef UDP_TX_ARB_TIMEOUT_EN
            stall_q <= stall_d;
`endif
        end
    end

    // Next-state logic: arbitrate in idle, hold the grant until packet end.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
`ifdef UDP_TX_ARB_TIMEOUT_EN
        stall_d = stall_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
                stall_d = '0;
`endif
                if (pick_vld_s) begin
                    state_d = S_FWD;
                    grant_d = pick_oh_s;
                    gidx_d  = pick_idx_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FWD: begin
                if (sel_valid_s && i_tx_udp_payload_axis_tready && sel_last_s) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end else begin
                    state_d = S_FWD;
                end
`ifdef UDP_TX_ARB_TIMEOUT_EN
                if (sel_valid_s && i_tx_udp_payload_axis_tready) begin
                    stall_d = '0;
                end else if (!sel_valid_s) begin
                    if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ABORT;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end else begin
                    stall_d = stall_q;
                end
`endif
            end
            S_ABORT: begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
                if (i_tx_udp_payload_axis_tready) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ABORT;
                end
`else
                state_d = S_IDLE;
                grant_d = '0;
`endif
            end
            S_DRAIN: begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
                if (sel_valid_s && sel_last_s) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end else begin
                    state_d = S_DRAIN;
                end
`else
                state_d = S_IDLE;
                grant_d = '0;
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: pass-through in forward, abort byte, silent drain.
    always_comb begin
        o_tx_udp_payload_axis_tdata  = 8'h00;
        o_tx_udp_payload_axis_tvalid = 1'b0;
        o_tx_udp_payload_axis_tlast  = 1'b0;
        o_src_tready                 = '0;
        o_busy                       = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
            end
            S_FWD: begin
                o_busy                       = 1'b1;
                o_tx_udp_payload_axis_tdata  = sel_data_s;
                o_tx_udp_payload_axis_tvalid = sel_valid_s;
                o_tx_udp_payload_axis_tlast  = sel_last_s;
                o_src_tready                 = grant_q & {N_SRC{i_tx_udp_payload_axis_tready}};
            end
            S_ABORT: begin
                o_busy = 1'b1;
`ifdef UDP_TX_ARB_TIMEOUT_EN
                o_tx_udp_payload_axis_tdata  = ABORT_BYTE;
                o_tx_udp_payload_axis_tvalid = 1'b1;
                o_tx_udp_payload_axis_tlast  = 1'b1;
`endif
            end
            S_DRAIN: begin
                o_busy = 1'b1;
`ifdef UDP_TX_ARB_TIMEOUT_EN
                o_src_tready = grant_q;
`endif
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: per-source byte queues feed the
// DUT, expected TX beats are queued in predicted grant order and compared
// whenever the TX stream accepts a beat.
module tb_udp_tx_arbiter;

    localparam int N = 4;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
        logic       last;
        logic       abort;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*8-1:0] src_tdata;
    logic [N-1:0]   src_tvalid;
    logic [N-1:0]   src_tlast;
    logic [N-1:0]   src_tready;
    logic [7:0]     tx_tdata;
    logic           tx_tvalid;
    logic           tx_tlast;
    logic           tx_tready;
    logic [N-1:0]   grant;
    logic           busy;

    int             checks   = 0;
    int             failures = 0;
    int             fire_cnt = 0;
    exp_t           exp_q[$];
    logic [8:0]     srcq[N][$];
    logic [N-1:0]   hold     = '0;
    logic [N-1:0]   accept   = '0;
    logic           tog_en   = 1'b0;
    logic           tog      = 1'b1;
    logic           chk_idle = 1'b0;
    logic           prev_last = 1'b0;

    udp_tx_arbiter #(
        .N_SRC          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                        (clk),
        .i_rst_n                      (rst_n),
        .i_src_tdata                  (src_tdata),
        .i_src_tvalid                 (src_tvalid),
        .i_src_tlast                  (src_tlast),
        .o_src_tready                 (src_tready),
        .o_tx_udp_payload_axis_tdata  (tx_tdata),
        .o_tx_udp_payload_axis_tvalid (tx_tvalid),
        .o_tx_udp_payload_axis_tlast  (tx_tlast),
        .i_tx_udp_payload_axis_tready (tx_tready),
        .o_grant                      (grant),
        .o_busy                       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_src(input int s, input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) srcq[s].push_back({(i == len - 1), base + 8'(i)});
    endtask

    task automatic push_exp(input int s, input logic [7:0] base, input int n, input logic full);
        for (int i = 0; i < n; i++) exp_q.push_back('{3'(s), base + 8'(i), full && (i == n - 1), 1'b0});
    endtask

    task automatic drive_only();
        logic [8:0] h;
        for (int k = 0; k < N; k++) begin
            if (srcq[k].size() > 0 && !hold[k]) begin
                h = srcq[k][0];
                src_tvalid[k]        = 1'b1;
                src_tdata[k*8 +: 8]  = h[7:0];
                src_tlast[k]         = h[8];
            end else begin
                src_tvalid[k]        = 1'b0;
                src_tdata[k*8 +: 8]  = 8'h00;
                src_tlast[k]         = 1'b0;
            end
        end
    endtask

    // Mid-cycle observation: scoreboard, bubble and idle checks.
    task automatic monitor();
        exp_t e;
        accept = src_tvalid & src_tready;
        chk("ready_outside_grant", 32'(src_tready & ~grant), 32'h0);
        if (chk_idle) begin
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_tvalid", 32'(tx_tvalid), 32'h0);
            chk("idle_tlast", 32'(tx_tlast), 32'h0);
            chk("idle_tdata", 32'(tx_tdata), 32'h0);
            chk("idle_src_tready", 32'(src_tready), 32'h0);
            chk_idle = 1'b0;
        end
        if (prev_last) begin
            chk("bubble_grant", 32'(grant), 32'h0);
            chk("bubble_busy", 32'(busy), 32'h0);
            prev_last = 1'b0;
        end
        if (tx_tvalid && tx_tready) begin
            fire_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_beat observed=%0h expected=none", tx_tdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_tdata", 32'(tx_tdata), 32'(e.data));
                chk("tx_tlast", 32'(tx_tlast), 32'(e.last));
                chk("tx_grant", 32'(grant), 32'(4'b0001 << e.src));
                prev_last = e.last && !e.abort;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (accept[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        end
        if (tog_en) begin
            tx_tready = tog;
            tog       = ~tog;
        end else begin
            tx_tready = 1'b1;
            tog       = 1'b1;
        end
        drive_only();
    endtask

    task automatic wait_fires(input string tag, input int target, input int budget);
        int n = 0;
        while (fire_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(fire_cnt >= target), 32'h1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int base;
        rst_n      = 1'b0;
        src_tdata  = '0;
        src_tvalid = '0;
        src_tlast  = '0;
        tx_tready  = 1'b1;
        repeat (2) step();
        chk_idle = 1'b1;
        step();
        rst_n = 1'b1;

        // Sources 0 and 2 request together: 0 first, then 2 after a bubble.
        push_src(0, 8'hA0, 3);
        push_src(2, 8'hC0, 4);
        push_exp(0, 8'hA0, 3, 1'b1);
        push_exp(2, 8'hC0, 4, 1'b1);
        drive_only();
        wait_done("sb_dual_req", 40);
        repeat (2) step();

        // Source 3 stalls mid-packet while source 0 requests: no preemption.
        base = fire_cnt;
        push_src(3, 8'h30, 4);
        push_exp(3, 8'h30, 4, 1'b1);
        push_exp(0, 8'h01, 2, 1'b1);
        drive_only();
        wait_fires("wait_src3_first", base + 1, 20);
        hold[3] = 1'b1;
        push_src(0, 8'h01, 2);
        drive_only();
        repeat (5) step();
        chk("held_grant", 32'(grant), 32'h8);
        hold[3] = 1'b0;
        drive_only();
        wait_done("sb_no_preempt", 40);
        repeat (2) step();

        // Source 1, 5 bytes under toggling downstream ready.
        tog_en = 1'b1;
        tog    = 1'b1;
        push_src(1, 8'h11, 5);
        push_exp(1, 8'h11, 5, 1'b1);
        drive_only();
        wait_done("sb_backpressure", 60);
        tog_en = 1'b0;
        repeat (2) step();

        // One-cycle reset mid-packet drops the rest of source 3's packet.
        base = fire_cnt;
        push_src(3, 8'h60, 6);
        push_exp(3, 8'h60, 3, 1'b0);
        drive_only();
        wait_fires("wait_src3_mid", base + 2, 20);
        rst_n = 1'b0;
        step();
        srcq[3].delete();
        drive_only();
        rst_n    = 1'b1;
        chk_idle = 1'b1;
        step();
        chk("sb_reset_drop", 32'(exp_q.size()), 32'h0);
        push_src(1, 8'h70, 3);
        push_exp(1, 8'h70, 3, 1'b1);
        drive_only();
        wait_done("sb_after_reset", 40);
        repeat (2) step();

        // Fresh reset, then all four sources request: order 0,1,2,3,0.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        push_src(0, 8'h80, 3);
        push_src(0, 8'h84, 3);
        push_src(1, 8'h90, 3);
        push_src(2, 8'hB0, 3);
        push_src(3, 8'hD0, 3);
        push_exp(0, 8'h80, 3, 1'b1);
        push_exp(1, 8'h90, 3, 1'b1);
        push_exp(2, 8'hB0, 3, 1'b1);
        push_exp(3, 8'hD0, 3, 1'b1);
        push_exp(0, 8'h84, 3, 1'b1);
        drive_only();
        wait_done("sb_round_robin", 100);
        repeat (2) step();

`ifdef UDP_TX_ARB_TIMEOUT_EN
        // Source 2 stalls after 2 bytes: abort byte, then silent drain.
        base = fire_cnt;
        push_src(2, 8'h20, 5);
        push_exp(2, 8'h20, 2, 1'b0);
        exp_q.push_back('{3'd2, 8'h00, 1'b1, 1'b1});
        drive_only();
        wait_fires("wait_src2_two", base + 2, 20);
        hold[2] = 1'b1;
        drive_only();
        wait_fires("wait_abort", base + 3, 40);
        chk("drain_busy", 32'(busy), 32'h1);
        hold[2] = 1'b0;
        drive_only();
        begin
            int n = 0;
            while (srcq[2].size() != 0 && n < 20) begin
                step();
                n++;
            end
        end
        chk("drain_consumed", 32'(srcq[2].size()), 32'h0);
        chk_idle = 1'b1;
        step();
        repeat (2) step();
`endif

        for (int k = 0; k < N; k++) chk("src_queue_empty", 32'(srcq[k].size()), 32'h0);
        chk("sb_final_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
